keypad_writer: RTL

KEYPAD_WRITER -- requirements
Module: keypad_writer

---
 rtl/keypad_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/keypad_writer.sv
// 4x4 keypad scanner: column scan, per-frame key detection, debounce FSM and
// a single-cycle write strobe carrying the key code and an auto-incrementing slot.
module keypad_writer #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       wr,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_N);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] HELD     = 2'd3;

  logic [3:0]       rows_meta;
  logic [3:0]       rows_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic             acc_hit;
  logic [3:0]       acc_code;

  logic [1:0] state, state_d;
  logic [3:0] cand, cand_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] rcnt, rcnt_d;
  logic [2:0] ptr, ptr_d;

  logic       col_end_c;
  logic       frame_end_c;
  logic       sample_hit_c;
  logic [1:0] row_idx_c;
  logic [3:0] sample_code_c;
  logic       frame_hit_c;
  logic [3:0] frame_code_c;
  logic [1:0] col_next_c;

  assign col_end_c     = (div_cnt == DIV_LAST);
  assign frame_end_c   = col_end_c && (col == 2'd3);
  assign col_next_c    = col + 2'd1;
  assign sample_hit_c  = ~&rows_sync;
  assign sample_code_c = {row_idx_c, col};
  assign frame_hit_c   = acc_hit | sample_hit_c;
  assign frame_code_c  = acc_hit ? acc_code : sample_code_c;

  // Lowest active row index wins when several rows read low together.
  always_comb begin
    row_idx_c = 2'd3;
    if (!rows_sync[0])      row_idx_c = 2'd0;
    else if (!rows_sync[1]) row_idx_c = 2'd1;
    else if (!rows_sync[2]) row_idx_c = 2'd2;
  end

  // Synchronizer, free-running column scan and per-frame first-hit capture.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
      div_cnt   <= '0;
      col       <= 2'd0;
      Cols      <= 4'b1110;
      acc_hit   <= 1'b0;
      acc_code  <= 4'd0;
    end else begin
      rows_meta <= Rows;
      rows_sync <= rows_meta;
      if (col_end_c) begin
        div_cnt <= '0;
        col     <= col_next_c;
        Cols    <= ~(4'b0001 << col_next_c);
        if (frame_end_c) begin
          acc_hit  <= 1'b0;
          acc_code <= 4'd0;
        end else if (!acc_hit && sample_hit_c) begin
          acc_hit  <= 1'b1;
          acc_code <= sample_code_c;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cand     <= 4'd0;
      cnt      <= 4'd0;
      rcnt     <= 4'd0;
      ptr      <= 3'd0;
      num      <= 4'd0;
      sel      <= 3'd0;
      wr       <= 1'b0;
      key_held <= 1'b0;
    end else begin
      state    <= state_d;
      cand     <= cand_d;
      cnt      <= cnt_d;
      rcnt     <= rcnt_d;
      ptr      <= ptr_d;
      wr       <= (state_d == WRITE);
      key_held <= (state_d == WRITE) || (state_d == HELD);
      if (state_d == WRITE) begin
        num <= cand_d;
        sel <= ptr;
      end
    end
  end

  // Next-state logic; everything except WRITE advances only on a frame end.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    rcnt_d  = rcnt;
    ptr_d   = ptr;
    case (state)
      IDLE: begin
        if (frame_end_c && frame_hit_c) begin
          cand_d  = frame_code_c;
          cnt_d   = 4'd1;
          state_d = (DEB_N == 4'd1) ? WRITE : DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (frame_end_c) begin
          if (frame_hit_c && (frame_code_c == cand)) begin
            cnt_d = cnt + 4'd1;
            if (cnt_d == DEB_N) state_d = WRITE;
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        ptr_d   = ptr + 3'd1;
        cnt_d   = 4'd0;
        rcnt_d  = 4'd0;
        state_d = HELD;
      end
      HELD: begin
        if (frame_end_c) begin
          if (frame_hit_c) begin
            rcnt_d = 4'd0;
          end else begin
            rcnt_d = rcnt + 4'd1;
            if (rcnt_d == DEB_N) begin
              rcnt_d  = 4'd0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
